// File: rtl/xor_checksum_stream.sv
// Streaming XOR checksum: folds a frame of WIDTH-bit words into one checksum word.
// Generate mode reports the checksum; check mode flags frames that do not XOR to zero.
module xor_checksum_stream #(
  parameter int WIDTH = 8,
  parameter int MAX_LEN = 16,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_len,
  output logic             out_error,
  output logic             out_trunc,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             mode_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             out_error_reg;
  logic             out_trunc_reg;

  logic [WIDTH-1:0] acc_next;
  logic [LEN_W-1:0] cnt_next;
  logic             accept;
  logic             from_accum;
  logic             frame_mode;
  logic             closing;

  assign accept     = in_valid && in_ready_reg;
  assign from_accum = (state_reg == ACCUM);

  // The first beat of a frame seeds the accumulator; later beats fold into it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fold
      assign acc_next[gi] = in_data[gi] ^ (acc_reg[gi] & from_accum);
    end
  endgenerate

  assign cnt_next   = from_accum ? (cnt_reg + LEN_W'(1)) : LEN_W'(1);
  assign frame_mode = from_accum ? mode_reg : mode;
  // A frame closes on its marked last word or when the beat count hits the limit.
  assign closing    = in_last || (cnt_next == MAX_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_error_reg <= 1'b0;
      out_trunc_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            if (!from_accum) begin
              mode_reg <= mode;
            end
            if (closing) begin
              state_reg     <= HOLD;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              out_trunc_reg <= !in_last;
              out_error_reg <= frame_mode && (acc_next != '0);
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_error_reg <= 1'b0;
            out_trunc_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          acc_reg       <= '0;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          out_error_reg <= 1'b0;
          out_trunc_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = acc_reg;
  assign out_len   = cnt_reg;
  assign out_error = out_error_reg;
  assign out_trunc = out_trunc_reg;

endmodule
